// File: rtl/vecmac_pkg.sv
// Shared constants and FSM encoding for the vecmac result path.
// PSUM_W and MAX_PSUM describe the mul4x8x8 output stream.
package vecmac_pkg;

  localparam int PSUM_W   = 18;
  localparam int MAX_PSUM = 260100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/vecmac_res_fifo.sv
// Synchronous result FIFO: push/pop, full/empty flags, head output.
// Ports: clk, rst_n, push, din, pop, full, empty, head.
module vecmac_res_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [AW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd];
  assign pop_ok  = pop && !empty;
  // a push into a full FIFO is accepted only when a pop frees the slot
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr] <= din;
        wr      <= wr + 1'b1;
      end
      if (pop_ok)
        rd <= rd + 1'b1;
      if (push_ok && !pop_ok)
        count <= count + 1'b1;
      else if (!push_ok && pop_ok)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/vecmac_acc_drain.sv
// Accumulates cfg_len partial sums per result and queues results.
// Ports: clk, rst_n, cfg_len/start/stop, in_valid/in_psum,
//   out_valid/out_ready/out_acc, busy, res_ovf, unexp_beat,
//   cfg_err, sat. Optional macro: VECMAC_ACC_SAT_EN.
module vecmac_acc_drain
  import vecmac_pkg::*;
#(
  parameter int PSUM_W    = vecmac_pkg::PSUM_W,
  parameter int ACC_W     = 32,
  parameter int LEN_W     = 16,
  parameter int RES_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              in_valid,
  input  logic [PSUM_W-1:0] in_psum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              busy,
  output logic              res_ovf,
  output logic              unexp_beat,
  output logic              cfg_err,
  output logic              sat
);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nx;
  logic              stop_pend;
  logic              add_ovf;
  logic              beat;
  logic              last;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

`ifdef VECMAC_ACC_SAT_EN
  logic [ACC_W:0] sum;
  logic           sat_q;

  // clamp at all-ones; later beats carry again, so it sticks
  always_comb begin
    sum     = {1'b0, acc} + (ACC_W+1)'(in_psum);
    add_ovf = sum[ACC_W];
    acc_nx  = add_ovf ? '1 : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      sat_q <= 1'b0;
    else if (beat && add_ovf)
      sat_q <= 1'b1;
  end

  assign sat = sat_q;
`else
  always_comb begin
    add_ovf = 1'b0;
    acc_nx  = acc + ACC_W'(in_psum);
  end

  assign sat = add_ovf;
`endif

  assign beat = (state == ST_RUN) && in_valid;
  assign last = (cnt == len_q - 1'b1);
  assign push = beat && last;
  assign pop  = out_valid && out_ready;
  assign busy = (state == ST_RUN);
  assign out_valid = !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      cnt        <= '0;
      acc        <= '0;
      stop_pend  <= 1'b0;
      res_ovf    <= 1'b0;
      unexp_beat <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      if (push && full && !pop)
        res_ovf <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (in_valid)
            unexp_beat <= 1'b1;
          if (cfg_start) begin
            if (cfg_len == '0) begin
              cfg_err <= 1'b1;
            end else begin
              state     <= ST_RUN;
              len_q     <= cfg_len;
              cnt       <= '0;
              acc       <= '0;
              stop_pend <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            if (last) begin
              acc <= '0;
              cnt <= '0;
              if (stop_pend || cfg_stop) begin
                state     <= ST_IDLE;
                stop_pend <= 1'b0;
              end
            end else begin
              acc <= acc_nx;
              cnt <= cnt + 1'b1;
              if (cfg_stop)
                stop_pend <= 1'b1;
            end
          end else if (cfg_stop && cnt == '0) begin
            // nothing in flight: leave immediately
            state     <= ST_IDLE;
            stop_pend <= 1'b0;
          end else if (cfg_stop) begin
            stop_pend <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  vecmac_res_fifo #(
    .W     (ACC_W),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (acc_nx),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (out_acc)
  );

endmodule

// File: tb/tb_vecmac_acc_drain.sv
// Directed test for vecmac_acc_drain with ACC_W=20.
// Covers single/multi-beat, backpressure, saturation, control, reset.
module tb_vecmac_acc_drain;

  localparam int ACC_W = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [15:0]      cfg_len;
  logic             cfg_start;
  logic             cfg_stop;
  logic             in_valid;
  logic [17:0]      in_psum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             busy;
  logic             res_ovf;
  logic             unexp_beat;
  logic             cfg_err;
  logic             sat;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vecmac_acc_drain #(
    .ACC_W (ACC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_len    (cfg_len),
    .cfg_start  (cfg_start),
    .cfg_stop   (cfg_stop),
    .in_valid   (in_valid),
    .in_psum    (in_psum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .busy       (busy),
    .res_ovf    (res_ovf),
    .unexp_beat (unexp_beat),
    .cfg_err    (cfg_err),
    .sat        (sat)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic start(input logic [15:0] len);
    cfg_len   = len;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic stop();
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
  endtask

  task automatic beat(input logic [17:0] v);
    in_valid = 1'b1;
    in_psum  = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_acc"},   32'(out_acc),   0);
    check({tag, "_busy"},  32'(busy),      0);
    check({tag, "_flags"},
          {28'd0, res_ovf, unexp_beat, cfg_err, sat}, 0);
  endtask

  logic [17:0] sb_vals [3] = '{18'd0, 18'd65025, 18'd7};

  initial begin
    rst_n     = 1'b0;
    cfg_len   = '0;
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    in_valid  = 1'b0;
    in_psum   = '0;
    out_ready = 1'b0;
    step();
    step();
    check_idle("rst");
    rst_n = 1'b1;

    // single-beat results, back to back
    out_ready = 1'b1;
    start(16'd1);
    check("sb_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      beat(sb_vals[i]);
      check("sb_valid", 32'(out_valid), 1);
      check("sb_acc", 32'(out_acc), 32'(sb_vals[i]));
    end
    step();
    check("sb_drained", 32'(out_valid), 0);
    stop();
    check("sb_stop_busy", 32'(busy), 0);

    // four beats with idle gaps
    start(16'd4);
    for (int i = 0; i < 4; i++) begin
      beat(18'd260100);
      if (i < 3) begin
        check("mb_early", 32'(out_valid), 0);
        step();
      end
    end
    check("mb_valid", 32'(out_valid), 1);
    check("mb_acc", 32'(out_acc), 1040400);
    step();
    stop();

    // backpressure: fifth result dropped
    out_ready = 1'b0;
    start(16'd1);
    for (int k = 1; k <= 5; k++)
      beat(18'(k));
    check("bp_ovf", 32'(res_ovf), 1);
    check("bp_head", 32'(out_acc), 1);
    step();
    step();
    check("bp_stable", 32'(out_acc), 1);
    check("bp_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("bp_drain_v", 32'(out_valid), 1);
      check("bp_drain", 32'(out_acc), 32'(k));
      step();
    end
    check("bp_empty", 32'(out_valid), 0);
    stop();

    // eight max beats overflow a 20-bit accumulator
    do_reset();
    start(16'd8);
    for (int i = 0; i < 8; i++)
      beat(18'd260100);
`ifdef VECMAC_ACC_SAT_EN
    check("sat_acc", 32'(out_acc), 1048575);
    check("sat_flag", 32'(sat), 1);
`else
    check("wrap_acc", 32'(out_acc), 1032224);
    check("wrap_flag", 32'(sat), 0);
`endif
    step();
    stop();

    // control corners
    do_reset();
    start(16'd0);
    check("cfg_err", 32'(cfg_err), 1);
    check("cfg_err_busy", 32'(busy), 0);
    beat(18'd9);
    check("unexp", 32'(unexp_beat), 1);
    check("unexp_noout", 32'(out_valid), 0);
    start(16'd3);
    beat(18'd10);
    cfg_stop = 1'b1;
    beat(18'd20);
    cfg_stop = 1'b0;
    check("stop_busy_mid", 32'(busy), 1);
    beat(18'd30);
    check("stop_busy_end", 32'(busy), 0);
    check("stop_valid", 32'(out_valid), 1);
    check("stop_acc", 32'(out_acc), 60);
    step();

    // reset in the middle of a result
    start(16'd4);
    beat(18'd100);
    beat(18'd100);
    do_reset();
    check_idle("mid_rst");
    start(16'd2);
    beat(18'd5);
    beat(18'd6);
    check("mid_rst_valid", 32'(out_valid), 1);
    check("mid_rst_acc", 32'(out_acc), 11);
    step();
    check("mid_rst_empty", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
